// File: rtl/qreg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : qreg_pkg                                                  |
// | Purpose  : Shared types and constants for the QBUS register bank:    |
// |            interrupt FSM state enum, default CSR bit positions and   |
// |            CSR bit-name constants.                                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package qreg_pkg;

  // Interrupt request FSM states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } irqState_t;

  // Register word width on the I/O bus
  localparam int c_DATA_W = 16;

  // Default CSR bit positions used by the interrupt logic
  localparam int c_IE_BIT_DEFAULT   = 6;
  localparam int c_DONE_BIT_DEFAULT = 7;

  // Conventional PDP-11 CSR bit names
  localparam int c_CSR_GO   = 0;
  localparam int c_CSR_IE   = 6;
  localparam int c_CSR_DONE = 7;
  localparam int c_CSR_ERR  = 15;

endpackage
`default_nettype wire

// File: rtl/qreg_irq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : qreg_irq                                                  |
// | Purpose  : CSR interrupt request generator. Detects the rising edge  |
// |            of arm (IE & DONE) and holds irq_req until the arbiter    |
// |            acknowledges or the device withdraws arm.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module qreg_irq
  import qreg_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic arm,
  input  logic irq_ack,
  output logic irq_req
);

  irqState_t r_state;
  irqState_t w_stateNext;
  logic      r_armPrev;

  // State register and one-cycle arm history for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_armPrev <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_armPrev <= arm;
    end
  end

  // Next-state and request output; a new request needs a fresh arm edge
  always_comb begin
    w_stateNext = r_state;
    irq_req     = 1'b0;
    case (r_state)
      IDLE: begin
        if (arm && !r_armPrev) begin
          w_stateNext = REQ;
        end
      end
      REQ: begin
        irq_req = 1'b1;
        if (irq_ack || (!arm && r_armPrev)) begin
          w_stateNext = IDLE;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/qreg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : qreg_bank                                                 |
// | Purpose  : Parametrised bank of QBUS-visible device registers with   |
// |            per-bit write masks, device load port, write-pending      |
// |            handshake flags and a CSR interrupt request.              |
// |            Optional macro QREG_BYTE_WRITE_EN enables byte-lane       |
// |            (DATOB) writes and odd-address matching.                  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module qreg_bank
  import qreg_pkg::*;
#(
  parameter int                  COUNT     = 4,
  parameter logic [16*COUNT-1:0] WMASK     = {{(COUNT-1){16'hFFFF}}, 16'hFF7F},
  parameter logic [16*COUNT-1:0] RESET_VAL = '0,
  parameter int                  IE_BIT    = c_IE_BIT_DEFAULT,
  parameter int                  DONE_BIT  = c_DONE_BIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [12:0]           iADDR,
  input  logic                  iBS7,
  input  logic                  iWTBT,
  output logic                  iADDR_MATCH,
  input  logic [15:0]           iWDATA,
  input  logic                  iWRITE,
  input  logic                  iWBYTE,
  output logic [15:0]           iRDATA,
  input  logic [12:0]           addr_base,
  input  logic [COUNT-1:0]      hw_load,
  input  logic [16*COUNT-1:0]   hw_data,
  output logic [16*COUNT-1:0]   reg_out,
  output logic [COUNT-1:0]      wr_pend,
  input  logic [COUNT-1:0]      wr_ack,
  output logic                  irq_req,
  input  logic                  irq_ack
);

  localparam int c_CBITS = $clog2(COUNT);

  logic                w_match;
  logic [c_CBITS-1:0]  w_idx;
  logic [15:0]         w_lanes;
  logic                w_wrEn;
  logic [15:0]         w_regArr [COUNT];
  logic                w_arm;
  logic                w_unused;

  // iWTBT and the in-bank address bits of addr_base carry no information here
  assign w_unused = &{1'b0, iWTBT, iWBYTE, addr_base[c_CBITS:0]};

  assign w_idx = iADDR[c_CBITS:1];

`ifdef QREG_BYTE_WRITE_EN
  assign w_match = iBS7 && (iADDR[12:c_CBITS+1] == addr_base[12:c_CBITS+1]);

  // Byte writes pick one lane by iADDR[0]; a word write at an odd address is dropped
  always_comb begin
    w_lanes = 16'h0000;
    if (iWBYTE) begin
      w_lanes = iADDR[0] ? 16'hFF00 : 16'h00FF;
    end else begin
      w_lanes = iADDR[0] ? 16'h0000 : 16'hFFFF;
    end
  end
`else
  assign w_match = iBS7 && !iADDR[0] &&
                   (iADDR[12:c_CBITS+1] == addr_base[12:c_CBITS+1]);
  assign w_lanes = 16'hFFFF;
`endif

  assign iADDR_MATCH = w_match;
  assign w_wrEn      = iWRITE && w_match && (|w_lanes);

  for (genvar gi = 0; gi < COUNT; gi++) begin : g_reg
    localparam logic [15:0] c_WM = WMASK[gi*16 +: 16];

    logic        r_reg;
    logic [15:0] r_val;
    logic [15:0] w_next;
    logic        w_busHit;
    logic        r_pend;

    assign w_busHit = w_wrEn && (w_idx == c_CBITS'(gi));

    // Bus owns WMASK=1 bits, device owns WMASK=0 bits, so both may update at once
    always_comb begin
      w_next = r_val;
      if (w_busHit) begin
        w_next = (w_next & ~(c_WM & w_lanes)) | (iWDATA & c_WM & w_lanes);
      end
      if (hw_load[gi]) begin
        w_next = (w_next & c_WM) | (hw_data[gi*16 +: 16] & ~c_WM);
      end
    end

    // Register contents and write-pending flag (set wins over ack)
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_val  <= RESET_VAL[gi*16 +: 16];
        r_pend <= 1'b0;
      end else begin
        r_val  <= w_next;
        r_pend <= w_busHit || (r_pend && !wr_ack[gi]);
      end
    end

    assign r_reg                = 1'b0;
    assign w_regArr[gi]         = r_val;
    assign reg_out[gi*16 +: 16] = r_val;
    assign wr_pend[gi]          = r_pend;
  end

  // Full word read regardless of iADDR[0]; bus released when not addressed
  assign iRDATA = w_match ? w_regArr[w_idx] : 16'bz;

  assign w_arm = reg_out[IE_BIT] & reg_out[DONE_BIT];

  qreg_irq u_irq (
    .clk     (clk),
    .reset_n (reset_n),
    .arm     (w_arm),
    .irq_ack (irq_ack),
    .irq_req (irq_req)
  );

endmodule
`default_nettype wire
